// File: rtl/ifd_fetch_decode.sv
// PDP-8 instruction fetch/decode unit: fetches at EXEC's PC, decodes memory-reference/op7 words.
// Optional feature: define IFD_HALT_EN to freeze the unit in HALTED after a decoded HLT.
package ifd_fetch_decode_pkg;

  typedef struct packed {
    logic        NOP;
    logic        AND;
    logic        TAD;
    logic        ISZ;
    logic        DCA;
    logic        JMS;
    logic        JMP;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA2;
    logic HLT;
    logic SMA;
    logic SZA;
    logic SNL;
    logic SPA;
    logic SNA;
    logic SZL;
    logic OSR;
  } pdp_op7_opcode_s;

endpackage

module ifd_fetch_decode
  import ifd_fetch_decode_pkg::*;
#(
  parameter logic [11:0] START_ADDR = 12'o200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [11:0]     PC_value,
  output logic            ifd_rd_req,
  output logic [11:0]     ifd_rd_addr,
  input  logic            ifd_rd_ack,
  input  logic [11:0]     ifd_rd_data,
  output logic [11:0]     base_addr,
  output pdp_mem_opcode_s pdp_mem_opcode,
  output pdp_op7_opcode_s pdp_op7_opcode,
  output logic            decode_valid,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    DECODE,
    HOLD,
    HALTED
  } state_e;

  state_e          state;
  pdp_mem_opcode_s mem_d;
  pdp_op7_opcode_s op7_d;
  pdp_mem_opcode_s mem_nop;
  pdp_op7_opcode_s op7_nop;

  assign base_addr = START_ADDR;

  always_comb begin
    mem_nop     = '0;
    mem_nop.NOP = 1'b1;
    op7_nop     = '0;
    op7_nop.NOP = 1'b1;
  end

  // Decode straight from the returning word so outputs register on the ack edge.
  always_comb begin
    mem_d = '0;
    op7_d = '0;
    case (ifd_rd_data[11:9])
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
        mem_d.AND = (ifd_rd_data[11:9] == 3'd0);
        mem_d.TAD = (ifd_rd_data[11:9] == 3'd1);
        mem_d.ISZ = (ifd_rd_data[11:9] == 3'd2);
        mem_d.DCA = (ifd_rd_data[11:9] == 3'd3);
        mem_d.JMS = (ifd_rd_data[11:9] == 3'd4);
        mem_d.JMP = (ifd_rd_data[11:9] == 3'd5);
        mem_d.mem_inst_addr = ifd_rd_data[7] ? {ifd_rd_addr[11:7], ifd_rd_data[6:0]}
                                             : {5'b0, ifd_rd_data[6:0]};
        op7_d.NOP = 1'b1;
      end
      3'd6: begin
        mem_d.NOP = 1'b1;
        op7_d.NOP = 1'b1;
      end
      default: begin
        mem_d.NOP = 1'b1;
        if (!ifd_rd_data[8]) begin
          op7_d.CLA1 = ifd_rd_data[7];
          op7_d.CLL  = ifd_rd_data[6];
          op7_d.CMA  = ifd_rd_data[5];
          op7_d.CML  = ifd_rd_data[4];
          op7_d.RAR  = ifd_rd_data[3] & ~ifd_rd_data[1];
          op7_d.RTR  = ifd_rd_data[3] &  ifd_rd_data[1];
          op7_d.RAL  = ifd_rd_data[2] & ~ifd_rd_data[1];
          op7_d.RTL  = ifd_rd_data[2] &  ifd_rd_data[1];
          op7_d.IAC  = ifd_rd_data[0];
          op7_d.CIA  = ifd_rd_data[5] &  ifd_rd_data[0];
          op7_d.NOP  = (ifd_rd_data == 12'o7000);
        end else if (!ifd_rd_data[0]) begin
          op7_d.CLA2 = ifd_rd_data[7];
          op7_d.SMA  = ifd_rd_data[6] & ~ifd_rd_data[3];
          op7_d.SZA  = ifd_rd_data[5] & ~ifd_rd_data[3];
          op7_d.SNL  = ifd_rd_data[4] & ~ifd_rd_data[3];
          op7_d.SPA  = ifd_rd_data[6] &  ifd_rd_data[3];
          op7_d.SNA  = ifd_rd_data[5] &  ifd_rd_data[3];
          op7_d.SZL  = ifd_rd_data[4] &  ifd_rd_data[3];
          op7_d.OSR  = ifd_rd_data[2];
          op7_d.HLT  = ifd_rd_data[1];
        end else begin
          op7_d.NOP = 1'b1;
        end
      end
    endcase
  end

`ifdef IFD_HALT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ifd_rd_req     <= 1'b0;
      ifd_rd_addr    <= '0;
      pdp_mem_opcode <= mem_nop;
      pdp_op7_opcode <= op7_nop;
      decode_valid   <= 1'b0;
`ifdef IFD_HALT_EN
      halted_q       <= 1'b0;
`endif
    end else begin
      decode_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            state       <= FETCH;
            ifd_rd_req  <= 1'b1;
            ifd_rd_addr <= PC_value;
          end
        end
        FETCH: state <= WAIT_MEM;
        WAIT_MEM: begin
          if (ifd_rd_ack) begin
            ifd_rd_req     <= 1'b0;
            pdp_mem_opcode <= mem_d;
            pdp_op7_opcode <= op7_d;
            decode_valid   <= 1'b1;
            state          <= DECODE;
          end
        end
        DECODE: begin
`ifdef IFD_HALT_EN
          if (pdp_op7_opcode.HLT) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= HOLD;
          end
`else
          state <= HOLD;
`endif
        end
        HOLD: begin
          if (stall) state <= IDLE;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifd_fetch_decode.sv
// Directed self-checking bench for ifd_fetch_decode; honours IFD_HALT_EN when defined.
module tb_ifd_fetch_decode;
  import ifd_fetch_decode_pkg::*;

  logic            clk;
  logic            reset;
  logic            stall;
  logic [11:0]     PC_value;
  logic            ifd_rd_req;
  logic [11:0]     ifd_rd_addr;
  logic            ifd_rd_ack;
  logic [11:0]     ifd_rd_data;
  logic [11:0]     base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            decode_valid;
  logic            halted;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  pdp_mem_opcode_s em;
  pdp_op7_opcode_s eo;

  ifd_fetch_decode #(.START_ADDR(12'o200)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .PC_value       (PC_value),
    .ifd_rd_req     (ifd_rd_req),
    .ifd_rd_addr    (ifd_rd_addr),
    .ifd_rd_ack     (ifd_rd_ack),
    .ifd_rd_data    (ifd_rd_data),
    .base_addr      (base_addr),
    .pdp_mem_opcode (pdp_mem_opcode),
    .pdp_op7_opcode (pdp_op7_opcode),
    .decode_valid   (decode_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pdp_mem_opcode_s mem_nop();
    pdp_mem_opcode_s m;
    m = '0;
    m.NOP = 1'b1;
    return m;
  endfunction

  function automatic pdp_op7_opcode_s op7_nop();
    pdp_op7_opcode_s o;
    o = '0;
    o.NOP = 1'b1;
    return o;
  endfunction

  // Leaves the bench at the FETCH cycle of a new transaction at address pc.
  task automatic start_fetch(input logic [11:0] pc);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    PC_value = pc;
    stall = 1'b0;
    @(negedge clk);
  endtask

  // Min-latency completion from FETCH: ack during WAIT_MEM, returns in DECODE cycle.
  task automatic ack_next(input logic [11:0] data);
    @(negedge clk);
    ifd_rd_ack  = 1'b1;
    ifd_rd_data = data;
    @(negedge clk);
    ifd_rd_ack  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; PC_value = '0; ifd_rd_ack = 1'b0; ifd_rd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_base_addr", 32'(base_addr), 32'(12'o200));
    chk("rst_req", 32'(ifd_rd_req), 32'd0);
    chk("rst_addr", 32'(ifd_rd_addr), 32'd0);
    chk("rst_mem", 32'(pdp_mem_opcode), 32'(mem_nop()));
    chk("rst_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));
    chk("rst_dv", 32'(decode_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stall_no_req", 32'(ifd_rd_req), 32'd0);

    // TAD current page, min latency, PC change during WAIT_MEM
    start_fetch(12'o0345);
    chk("tad_req", 32'(ifd_rd_req), 32'd1);
    chk("tad_addr", 32'(ifd_rd_addr), 32'(12'o0345));
    @(negedge clk);
    chk("tad_wait_req", 32'(ifd_rd_req), 32'd1);
    chk("tad_wait_dv", 32'(decode_valid), 32'd0);
    PC_value = 12'o7777; ifd_rd_ack = 1'b1; ifd_rd_data = 12'o1234;
    @(negedge clk);
    ifd_rd_ack = 1'b0;
    em = '0; em.TAD = 1'b1; em.mem_inst_addr = 12'o0234;
    chk("tad_dv", 32'(decode_valid), 32'd1);
    chk("tad_mem", 32'(pdp_mem_opcode), 32'(em));
    chk("tad_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));
    chk("tad_req_drop", 32'(ifd_rd_req), 32'd0);
    @(negedge clk);
    chk("tad_dv_pulse", 32'(decode_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_no_refetch", 32'(ifd_rd_req), 32'd0);
    chk("hold_outputs", 32'(pdp_mem_opcode), 32'(em));

    // 7041 at PC 7777; ack during FETCH cycle must be ignored
    start_fetch(12'o7777);
    chk("cia_addr", 32'(ifd_rd_addr), 32'(12'o7777));
    ifd_rd_ack = 1'b1; ifd_rd_data = 12'o7041;
    @(negedge clk);
    ifd_rd_ack = 1'b0; ifd_rd_data = '0;
    chk("early_ack_dv", 32'(decode_valid), 32'd0);
    chk("early_ack_req", 32'(ifd_rd_req), 32'd1);
    @(negedge clk);
    ifd_rd_ack = 1'b1; ifd_rd_data = 12'o7041;
    @(negedge clk);
    ifd_rd_ack = 1'b0;
    eo = '0; eo.CMA = 1'b1; eo.IAC = 1'b1; eo.CIA = 1'b1;
    chk("cia_dv", 32'(decode_valid), 32'd1);
    chk("cia_op7", 32'(pdp_op7_opcode), 32'(eo));
    chk("cia_mem", 32'(pdp_mem_opcode), 32'(mem_nop()));

    // 7006 with ack delayed 5 cycles, PC wandering meanwhile
    start_fetch(12'o0100);
    for (int i = 0; i < 5; i++) begin
      PC_value = 12'(12'o0555 + i);
      @(negedge clk);
      chk("delay_req", 32'(ifd_rd_req), 32'd1);
      chk("delay_addr", 32'(ifd_rd_addr), 32'(12'o0100));
    end
    ifd_rd_ack = 1'b1; ifd_rd_data = 12'o7006;
    @(negedge clk);
    ifd_rd_ack = 1'b0;
    eo = '0; eo.RTL = 1'b1;
    chk("rtl_dv", 32'(decode_valid), 32'd1);
    chk("rtl_op7", 32'(pdp_op7_opcode), 32'(eo));

    // JMP current page at PC 7777: no carry out of page
    start_fetch(12'o7777);
    ack_next(12'o5377);
    em = '0; em.JMP = 1'b1; em.mem_inst_addr = 12'o7777;
    chk("jmp_mem", 32'(pdp_mem_opcode), 32'(em));
    chk("jmp_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));

    // AND page zero: page bit clear
    start_fetch(12'o1765);
    ack_next(12'o0123);
    em = '0; em.AND = 1'b1; em.mem_inst_addr = 12'o0123;
    chk("and_mem", 32'(pdp_mem_opcode), 32'(em));

    // IOT
    start_fetch(12'o0020);
    ack_next(12'o6046);
    chk("iot_dv", 32'(decode_valid), 32'd1);
    chk("iot_mem", 32'(pdp_mem_opcode), 32'(mem_nop()));
    chk("iot_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));

    // Group 2, reverse-sense skip
    start_fetch(12'o0021);
    ack_next(12'o7650);
    eo = '0; eo.CLA2 = 1'b1; eo.SNA = 1'b1;
    chk("grp2_op7", 32'(pdp_op7_opcode), 32'(eo));

    // Reset during WAIT_MEM, then a late ack
    start_fetch(12'o0400);
    @(negedge clk);
    reset = 1'b1; stall = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(ifd_rd_req), 32'd0);
    chk("midrst_addr", 32'(ifd_rd_addr), 32'd0);
    chk("midrst_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));
    reset = 1'b0; ifd_rd_ack = 1'b1; ifd_rd_data = 12'o7041;
    repeat (2) @(negedge clk);
    ifd_rd_ack = 1'b0;
    chk("late_ack_dv", 32'(decode_valid), 32'd0);
    chk("late_ack_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));
    chk("late_ack_req", 32'(ifd_rd_req), 32'd0);

    // Group 3 reports op7 NOP only
    start_fetch(12'o0030);
    ack_next(12'o7401);
    chk("grp3_dv", 32'(decode_valid), 32'd1);
    chk("grp3_op7", 32'(pdp_op7_opcode), 32'(op7_nop()));

    // HLT
    start_fetch(12'o0200);
    ack_next(12'o7402);
    eo = '0; eo.HLT = 1'b1;
    chk("hlt_dv", 32'(decode_valid), 32'd1);
    chk("hlt_op7", 32'(pdp_op7_opcode), 32'(eo));
    @(negedge clk);
`ifdef IFD_HALT_EN
    chk("halted_set", 32'(halted), 32'd1);
    for (int i = 0; i < 6; i++) begin
      stall = ~stall;
      @(negedge clk);
      chk("halted_no_req", 32'(ifd_rd_req), 32'd0);
      chk("halted_hold", 32'(halted), 32'd1);
    end
    chk("halted_frozen", 32'(pdp_op7_opcode), 32'(eo));
`else
    chk("halted_tied", 32'(halted), 32'd0);
    stall = 1'b1;
    @(negedge clk);
    PC_value = 12'o0201; stall = 1'b0;
    @(negedge clk);
    chk("post_hlt_req", 32'(ifd_rd_req), 32'd1);
    chk("post_hlt_addr", 32'(ifd_rd_addr), 32'(12'o0201));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifd_fetch_decode.md
# ifd_fetch_decode

Instruction fetch/decode unit for the PDP-8 pipeline: fetches a 12-bit instruction from memory at the address supplied by EXEC, decodes it, and presents decoded memory-reference or operate (op7) signals to EXEC. It is the decoder end of the `stall`/`PC_value` ↔ `pdp_mem_opcode`/`pdp_op7_opcode` interface, paced by EXEC's `stall`. It sits between the memory model and the EXEC unit and is the DUT for IFD unit-level validation.

## Interface
- `START_ADDR`, default `12'o200`: first-instruction address driven on `base_addr`.
- `clk` in 1: free-running clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: EXEC busy; 1 = hold, 0 = EXEC ready for the next instruction.
- `PC_value` in `ADDR_WIDTH` (12): current PC from EXEC; used as the fetch address.
- `ifd_rd_req` out 1: memory read request, level-held until ack.
- `ifd_rd_addr` out 12: memory read address.
- `ifd_rd_ack` in 1: memory returns `ifd_rd_data` valid this cycle.
- `ifd_rd_data` in 12: instruction word.
- `base_addr` out 12: start address for EXEC.
- `pdp_mem_opcode` out `pdp_mem_opcode_s`: fields NOP, AND, TAD, ISZ, DCA, JMS, JMP, mem_inst_addr[11:0].
- `pdp_op7_opcode` out `pdp_op7_opcode_s`: fields NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA1, CLA2, HLT, SMA, SZA, SNL, SPA, SNA, SZL, OSR.
- `decode_valid` out 1: one-cycle pulse when new decode outputs are presented.
- `halted` out 1: HLT decoded (only with `IFD_HALT_EN`).

## Operation
- States: IDLE, FETCH, WAIT_MEM, DECODE, HOLD, HALTED.
- IDLE: entered on reset. Moves to FETCH when `stall`==0.
- FETCH: drive `ifd_rd_req`=1 and `ifd_rd_addr`=`PC_value`, with the address captured on entry. Go to WAIT_MEM.
- WAIT_MEM: hold `ifd_rd_req` and the address until `ifd_rd_ack`. Latch `ifd_rd_data`, drop `ifd_rd_req`, go to DECODE.
- DECODE:
  - Update the opcode outputs and pulse `decode_valid`.
  - Go to HALTED if HLT is set and `IFD_HALT_EN` is defined; otherwise go to HOLD.
- HOLD: outputs are held. Wait for `stall`==1 (EXEC accepted), then go to IDLE.
- Decode rules, with instruction word `I`:
  - `I[11:9]`=0..5 maps to AND, TAD, ISZ, DCA, JMS, JMP. Exactly one is set. All op7 fields are 0 and op7 NOP=1.
  - mem_inst_addr = `I[7]` ? {fetch_addr[11:7], `I[6:0]`} : {5'b0, `I[6:0]`}.
  - Indirect bit `I[8]` is not resolved here; EXEC handles it.
- `I[11:9]`=6 (IOT): mem NOP=1 and op7 NOP=1. All other fields are 0.
- `I[11:9]`=7 is op7. All mem fields are 0 and mem NOP=1.
  - Group 1 (`I[8]`=0):
    - CLA1=`I[7]`, CLL=`I[6]`, CMA=`I[5]`, CML=`I[4]`.
    - RAR=`I[3]`&~`I[1]`, RTR=`I[3]`&`I[1]`, RAL=`I[2]`&~`I[1]`, RTL=`I[2]`&`I[1]`.
    - IAC=`I[0]`. CIA=CMA&IAC.
  - Group 2 (`I[8]`=1, `I[0]`=0):
    - CLA2=`I[7]`.
    - With `I[3]`=0: SMA=`I[6]`, SZA=`I[5]`, SNL=`I[4]`. With `I[3]`=1: SPA=`I[6]`, SNA=`I[5]`, SZL=`I[4]`.
    - OSR=`I[2]`, HLT=`I[1]`.
  - Group 3 (`I[8]`=1, `I[0]`=1): op7 NOP=1 only.
  - op7 NOP=1 when `I`==12'o7000 or Group 3.

## Timing
- Reset values:
  - all struct fields 0 except both NOP=1;
  - `ifd_rd_req`=0, `ifd_rd_addr`=0, `decode_valid`=0, `halted`=0;
  - `base_addr`=`START_ADDR`, held constant.
- Minimum fetch-to-decode latency: req at cycle N, ack at N+1, decode outputs and `decode_valid` at N+2.
- Ack in the same cycle req first rises is ignored. Ack is sampled only in WAIT_MEM.
- `PC_value` is sampled once, on the FETCH cycle. Changes during WAIT_MEM do not affect the address.
- `stall` toggling during FETCH or WAIT_MEM is ignored. Stall is evaluated only in IDLE and HOLD.
- `reset` mid-transaction: the next cycle is IDLE with reset values, and `ifd_rd_req` drops immediately. A late `ifd_rd_ack` is ignored.
- Address wrap: mem_inst_addr is 12-bit, so no carry occurs. PC 12'o7777 is fetched normally.

## Configuration
- `IFD_HALT_EN` defined:
  - a decoded HLT enters HALTED and sets `halted`=1;
  - no further requests are issued and outputs are frozen until `reset`.
- Undefined:
  - HLT is reported only via the struct field;
  - the FSM goes to HOLD and continues normally;
  - `halted` is tied to 0.

## Test plan
- Reset: assert `reset` 2 cycles → `base_addr`=12'o200, `ifd_rd_req`=0, mem NOP=1, op7 NOP=1.
- TAD current page: `PC_value`=12'o0345, data 12'o1234 (page bit set) → TAD=1, mem_inst_addr=12'o0234, `decode_valid` pulses 1 cycle after ack.
- Op7 group 1: data 12'o7041 → CMA=1, IAC=1, CIA=1, other op7 fields 0. Data 12'o7006 → RTL=1.
- Stall handshake: hold `stall`=1 in IDLE → no `ifd_rd_req`. Drop `stall` → req at `PC_value`. After decode, no new fetch until `stall` goes 1 then 0.
- Memory latency/reset: ack delayed 5 cycles → req and address stable throughout. Assert `reset` in WAIT_MEM → req 0 next cycle, later ack ignored.
- HLT: data 12'o7402 → HLT=1. With `IFD_HALT_EN`, `halted`=1 and no further req despite `stall` toggling. Without it, the next fetch proceeds normally.
